// File: rtl/jtag_tap_driver.sv
// JTAG initiator: walks a target TAP through reset, IR-scan and DR-scan sequences
// and returns the TDO bits captured during Shift-IR/Shift-DR.
module jtag_tap_driver #(
  parameter  int unsigned MAX_LEN = 32,
  parameter  int unsigned CLK_DIV = 2,
  localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               CK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic               cmd_reset,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCLK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int unsigned   PW      = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);

  typedef enum logic [2:0] {INIT_TLR, IDLE, PRE, SHIFT, POST, DONE} state_t;

  state_t             state, state_d;
  logic [PW-1:0]      ph, ph_d, ph_next;
  logic [2:0]         cnt, cnt_d;
  logic [LW-1:0]      bit_cnt, bit_d;
  logic [LW-1:0]      len_r, len_d;
  logic [MAX_LEN-1:0] data_r, data_d, cap, cap_d, rsp_data_d;
  logic               ir_r, ir_d, is_cmd, is_cmd_d;
  logic               ready_d, rsp_valid_d, tclk_d, tms_d, tdi_d;
  logic               tick_end, ticking;

  // Next-state, counters and registered-output values
  always_comb begin
    state_d     = state;
    ph_d        = ph;
    cnt_d       = cnt;
    bit_d       = bit_cnt;
    len_d       = len_r;
    data_d      = data_r;
    cap_d       = cap;
    ir_d        = ir_r;
    is_cmd_d    = is_cmd;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    tick_end    = (ph == PH_LAST);
    ph_next     = tick_end ? '0 : ph + PW'(1);

    case (state)
      INIT_TLR: begin
        ph_d = ph_next;
        if (tick_end) begin
          if (cnt == 3'd5) begin
            cnt_d    = '0;
            is_cmd_d = 1'b0;
            ready_d  = 1'b1;
            if (is_cmd) begin
              state_d     = DONE;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      IDLE, DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
        if (cmd_valid && cmd_ready) begin
          ready_d = 1'b0;
          ph_d    = '0;
          cnt_d   = '0;
          bit_d   = '0;
          cap_d   = '0;
          ir_d    = cmd_ir;
          data_d  = cmd_data;
          len_d   = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
          if (cmd_reset) begin
            is_cmd_d = 1'b1;
            state_d  = INIT_TLR;
          end else if (cmd_len == '0) begin
            // Zero-length scan completes without touching the TAP
            state_d     = DONE;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = PRE;
          end
        end
      end
      PRE: begin
        ph_d = ph_next;
        if (tick_end) begin
          if (cnt == (ir_r ? 3'd3 : 3'd2)) begin
            state_d = SHIFT;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      SHIFT: begin
        ph_d = ph_next;
        if (tick_end) begin
          cap_d = cap | (MAX_LEN'(TDO) << bit_cnt);
          if (bit_cnt == len_r - LW'(1)) begin
            state_d = POST;
            cnt_d   = '0;
          end else begin
            bit_d = bit_cnt + LW'(1);
          end
        end
      end
      POST: begin
        ph_d = ph_next;
        if (tick_end) begin
          if (cnt == 3'd1) begin
            state_d     = DONE;
            cnt_d       = '0;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap;
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      default: state_d = INIT_TLR;
    endcase

    // TMS/TDI are launched only on the first CK cycle of each tick
    ticking = state_d inside {INIT_TLR, PRE, SHIFT, POST};
    tclk_d  = ticking && (ph_d >= PH_HIGH);
    tms_d   = TMS;
    tdi_d   = TDI;
    if (ticking && (ph_d == '0)) begin
      tdi_d = 1'b0;
      case (state_d)
        INIT_TLR: tms_d = (cnt_d < 3'd5);
        PRE:      tms_d = ir_d ? (cnt_d < 3'd2) : (cnt_d == 3'd0);
        SHIFT: begin
          tms_d = (bit_d == len_d - LW'(1));
          tdi_d = |(data_d & (MAX_LEN'(1) << bit_d));
        end
        default:  tms_d = (cnt_d == 3'd0);
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CK) begin
    if (!TRST) begin
      state     <= INIT_TLR;
      ph        <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      len_r     <= '0;
      data_r    <= '0;
      cap       <= '0;
      ir_r      <= 1'b0;
      is_cmd    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      TCLK      <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
    end else begin
      state     <= state_d;
      ph        <= ph_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_d;
      len_r     <= len_d;
      data_r    <= data_d;
      cap       <= cap_d;
      ir_r      <= ir_d;
      is_cmd    <= is_cmd_d;
      cmd_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      TCLK      <= tclk_d;
      TMS       <= tms_d;
      TDI       <= tdi_d;
    end
  end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: directed and random scans against a per-tick reference
// model of the TMS/TDI streams, with a small target model supplying TDO.
module tb_jtag_tap_driver;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int unsigned TPC     = 2 * CLK_DIV;

  logic               CK = 1'b0, TRST = 1'b0;
  logic               cmd_valid = 1'b0, cmd_ir = 1'b0, cmd_reset = 1'b0;
  logic [LW-1:0]      cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               cmd_ready, rsp_valid, TCLK, TMS, TDI;
  logic [MAX_LEN-1:0] rsp_data;
  logic               TDO = 1'b0;

  jtag_tap_driver #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .CK(CK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_reset(cmd_reset), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TCLK(TCLK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CK = ~CK;

  int tests = 0, fails = 0;
  int stab_err = 0, tdo_mode = 0, acc_wait = 0, last_cyc = 0;
  bit tms_q[$], tdi_q[$], tdo_q[$];
  bit exp_tms[$], exp_tdi[$];
  int exp_pre = 0, exp_n = 0, exp_ticks = 0;
  logic tclk_prev = 1'b0, tms_hold = 1'b0, tdi_hold = 1'b0, byp = 1'b0;

  // Target side: record each tick at rising TCLK and present TDO for its high phase
  always @(negedge CK) begin
    if (TCLK === 1'b1 && tclk_prev !== 1'b1) begin
      tms_q.push_back(TMS);
      tdi_q.push_back(TDI);
      tms_hold = TMS;
      tdi_hold = TDI;
      case (tdo_mode)
        1:       TDO = TDI;
        2:       begin TDO = byp; byp = TDI; end
        default: TDO = 1'($urandom);
      endcase
      tdo_q.push_back(TDO);
    end else if (TCLK === 1'b1 && (TMS !== tms_hold || TDI !== tdi_hold)) begin
      stab_err++;
    end
    tclk_prev = TCLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] q2v(input bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) if (i < 64) v[i] = q[i];
    return v;
  endfunction

  // Reference TAP walk for one command
  function automatic void build_exp(bit ir, bit rst, int unsigned len, logic [MAX_LEN-1:0] data);
    int unsigned n = (len > MAX_LEN) ? MAX_LEN : len;
    exp_tms.delete(); exp_tdi.delete();
    exp_pre = 0;
    exp_n = 0;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        exp_tms.push_back(i < 5);
        exp_tdi.push_back(1'b0);
      end
      exp_ticks = 6;
      return;
    end
    exp_n = int'(n);
    exp_ticks = (n == 0) ? 0 : int'(n) + (ir ? 6 : 5);
    if (n == 0) return;
    exp_tms.push_back(1'b1);
    if (ir) exp_tms.push_back(1'b1);
    exp_tms.push_back(1'b0);
    exp_tms.push_back(1'b0);
    exp_pre = exp_tms.size();
    for (int i = 0; i < exp_pre; i++) exp_tdi.push_back(1'b0);
    for (int i = 0; i < int'(n); i++) begin
      exp_tms.push_back(i == int'(n) - 1);
      exp_tdi.push_back(data[i]);
    end
    exp_tms.push_back(1'b1); exp_tms.push_back(1'b0);
    exp_tdi.push_back(1'b0); exp_tdi.push_back(1'b0);
  endfunction

  task automatic init_seq(input string tag);
    int n = 0, rsp_seen = 0;
    TRST = 1'b0;
    @(negedge CK);
    check({tag, ":rst_tclk"}, 64'(TCLK), 64'(0));
    check({tag, ":rst_tms"}, 64'(TMS), 64'(1));
    check({tag, ":rst_tdi"}, 64'(TDI), 64'(0));
    check({tag, ":rst_ready"}, 64'(cmd_ready), 64'(0));
    check({tag, ":rst_rspv"}, 64'(rsp_valid), 64'(0));
    check({tag, ":rst_rspd"}, 64'(rsp_data), 64'(0));
    repeat (2) @(negedge CK);
    tms_q.delete(); tdi_q.delete(); tdo_q.delete();
    TRST = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge CK); n++;
      #1 if (rsp_valid === 1'b1) rsp_seen++;
    end
    check({tag, ":ready_cycles"}, 64'(n), 64'(6 * TPC));
    check({tag, ":ticks"}, 64'(tms_q.size()), 64'(6));
    check({tag, ":tms"}, q2v(tms_q), 64'h1F);
    check({tag, ":no_rsp"}, 64'(rsp_seen), 64'(0));
  endtask

  task automatic send(input bit ir, input bit rst, input int unsigned len,
                      input logic [MAX_LEN-1:0] data, input bit keep);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 500) begin @(negedge CK); n++; end
    acc_wait = n;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_reset = rst;
    cmd_len = LW'(len); cmd_data = data;
    @(posedge CK);
    tms_q.delete(); tdi_q.delete(); tdo_q.delete();
    build_exp(ir, rst, len, data);
    #1;
    if (!keep) begin
      cmd_valid = 1'b0; cmd_ir = 1'($urandom); cmd_reset = 1'($urandom);
      cmd_len = LW'($urandom); cmd_data = MAX_LEN'($urandom);
    end
  endtask

  task automatic collect(input string tag, input bit pulse_chk, input bit poke);
    int cyc = 1;
    logic [63:0] exp_rsp = '0;
    logic [MAX_LEN-1:0] held;
    forever begin
      @(negedge CK);
      if (rsp_valid === 1'b1 || cyc > 400) break;
      if (poke && cyc == 10) cmd_valid = 1'b1;
      if (poke && cyc == 11) cmd_valid = 1'b0;
      @(posedge CK); cyc++;
    end
    last_cyc = cyc;
    for (int i = 0; i < exp_n; i++)
      if (exp_pre + i < tdo_q.size()) exp_rsp[i] = tdo_q[exp_pre + i];
    check({tag, ":latency"}, 64'(cyc), 64'(exp_ticks * TPC + 1));
    check({tag, ":ready"}, 64'(cmd_ready), 64'(1));
    check({tag, ":ticks"}, 64'(tms_q.size()), 64'(exp_ticks));
    check({tag, ":tms"}, q2v(tms_q), q2v(exp_tms));
    check({tag, ":tdi"}, q2v(tdi_q), q2v(exp_tdi));
    check({tag, ":rsp"}, 64'(rsp_data), exp_rsp);
    held = rsp_data;
    if (pulse_chk) begin
      @(negedge CK);
      check({tag, ":pulse"}, 64'(rsp_valid), 64'(0));
      check({tag, ":hold"}, 64'(rsp_data), 64'(held));
      check({tag, ":idle"}, {62'd0, cmd_ready, TCLK}, 64'h2);
    end
  endtask

  initial begin
    logic [MAX_LEN-1:0] d;
    int n;
    init_seq("init");

    tdo_mode = 2;
    send(1'b0, 1'b0, 8, 32'hA5, 1'b0);
    collect("dr_bypass", 1'b1, 1'b1);
    check("dr_bypass:rsp_const", 64'(rsp_data), 64'h4A);
    check("dr_bypass:lat_const", 64'(last_cyc), 64'd53);

    tdo_mode = 1;
    send(1'b1, 1'b0, 2, 32'h3, 1'b0);
    collect("ir_loop", 1'b1, 1'b0);
    check("ir_loop:tms_const", q2v(tms_q), 64'h63);
    check("ir_loop:rsp_const", 64'(rsp_data), 64'h3);

    tdo_mode = 0;
    send(1'b0, 1'b0, 0, MAX_LEN'($urandom), 1'b0);
    collect("len0", 1'b1, 1'b0);
    send(1'b0, 1'b0, 40, MAX_LEN'($urandom), 1'b0);
    collect("len40", 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      tdo_mode = int'($urandom_range(0, 2));
      send(1'($urandom), 1'b0, $urandom_range(0, 40), MAX_LEN'($urandom), 1'b0);
      collect($sformatf("rand%0d", i), 1'b1, 1'($urandom));
    end

    send(1'b0, 1'b1, 9, MAX_LEN'($urandom), 1'b0);
    collect("cmd_reset", 1'b1, 1'b0);

    // Abort a 16-bit DR scan during shift bit 5
    tdo_mode = 0;
    send(1'b0, 1'b0, 16, MAX_LEN'($urandom), 1'b0);
    n = 0;
    while (tms_q.size() < 9 && n < 200) begin @(negedge CK); n++; end
    check("abort:reach_shift", 64'(n < 200), 64'(1));
    init_seq("abort");

    d = MAX_LEN'($urandom);
    send(1'b0, 1'b0, 12, MAX_LEN'($urandom), 1'b1);
    cmd_ir = 1'b1; cmd_len = LW'(5); cmd_data = d;
    collect("b2b_a", 1'b0, 1'b0);
    send(1'b1, 1'b0, 5, d, 1'b0);
    check("b2b:accept_wait", 64'(acc_wait), 64'(0));
    collect("b2b_b", 1'b1, 1'b0);

    check("tms_tdi_stable", 64'(stab_err), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
